// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
//
// Prefetch buffer between the PC/redirect logic and decode. It keeps its own
// fetch PC, issues sequential word reads to a synchronous instruction ROM with
// one cycle of read latency, and queues the returned (address, instruction)
// pairs in a DEPTH-entry FIFO. Decode consumes entries over valid/ready.
// Redirect flushes the queue and restarts fetch at RedirectAddr.
//
// Handshake: an entry transfers on every rising CLK edge where InsValid and
// InsReady are both 1. InsValid never depends on InsReady. Ins/InsAddr are
// stable while InsValid=1 and InsReady=0.
//
// Optional build macro IPQ_BYPASS_EN: when the FIFO is empty, a live ROM
// response is presented on Ins/InsAddr in the cycle it arrives, and it is
// consumed without touching the FIFO if InsReady=1.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  fetch PC after reset (4-aligned)
// Ports
//   CLK, Reset        clock (rising edge), asynchronous active-high reset
//   Redirect          restart fetch at RedirectAddr (bits [1:0] ignored)
//   MemRd, MemAddr    ROM read strobe and 4-aligned word address
//   MemData           ROM data, valid in the cycle after MemRd
//   InsValid/Ready    decode handshake
//   Ins, InsAddr      head entry (instruction, its address)
//   Count             occupied FIFO entries
// -----------------------------------------------------------------------------
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectAddr,
  output logic                     MemRd,
  output logic [31:0]              MemAddr,
  input  logic [31:0]              MemData,
  output logic                     InsValid,
  input  logic                     InsReady,
  output logic [31:0]              Ins,
  output logic [31:0]              InsAddr,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fpc;
  logic [31:0]   pend_addr;
  logic          inflight;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fifo_ins  [DEPTH];
  logic [31:0]   fifo_addr [DEPTH];

  logic [CW:0]   occupancy;
  logic          live;
  logic          push;
  logic          pop;

  // Entries already stored plus the one still coming back from the ROM; a new
  // read is only allowed when its response is guaranteed a free slot.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign MemRd     = !Reset && !Redirect && (occupancy < (CW+1)'(DEPTH));
  assign MemAddr   = fpc;
  assign Count     = count;

  // A response arriving during Redirect belongs to the old stream. Since no
  // read is ever issued while Redirect is high, gating the response with
  // Redirect in its arrival cycle is all the kill logic needed.
  assign live = inflight && !Redirect;

`ifdef IPQ_BYPASS_EN
  logic bypass;
  assign bypass   = live && (count == '0);
  assign InsValid = ((count != '0) && !Redirect) || bypass;
  assign Ins      = bypass ? MemData   : fifo_ins[rd_ptr];
  assign InsAddr  = bypass ? pend_addr : fifo_addr[rd_ptr];
  assign pop      = (count != '0) && !Redirect && InsReady;
  assign push     = live && !(bypass && InsReady);
`else
  assign InsValid = (count != '0) && !Redirect;
  assign Ins      = fifo_ins[rd_ptr];
  assign InsAddr  = fifo_addr[rd_ptr];
  assign pop      = InsValid && InsReady;
  assign push     = live;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fpc       <= RESET_PC;
      pend_addr <= '0;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_ins[i]  <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (Redirect) begin
      fpc      <= RedirectAddr & 32'hFFFF_FFFC;
      inflight <= 1'b0;
      count    <= '0;
      // Empty the FIFO by pulling the write pointer back to the head slot so
      // Ins/InsAddr do not move until the next push-into-empty.
      wr_ptr   <= rd_ptr;
    end else begin
      inflight <= MemRd;
      if (MemRd) begin
        pend_addr <= fpc;
        fpc       <= fpc + 32'd4;
      end
      if (push) begin
        fifo_ins[wr_ptr]  <= MemData;
        fifo_addr[wr_ptr] <= pend_addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IPQ_BYPASS_EN
  localparam int          LAT      = 1;
`else
  localparam int          LAT      = 2;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectAddr = '0;
  logic        MemRd;
  logic [31:0] MemAddr;
  logic [31:0] MemData = '0;
  logic        InsValid;
  logic        InsReady = 1'b0;
  logic [31:0] Ins;
  logic [31:0] InsAddr;
  logic [2:0]  Count;

  always #5 CLK = ~CLK;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .Reset(Reset), .Redirect(Redirect), .RedirectAddr(RedirectAddr),
    .MemRd(MemRd), .MemAddr(MemAddr), .MemData(MemData),
    .InsValid(InsValid), .InsReady(InsReady), .Ins(Ins), .InsAddr(InsAddr),
    .Count(Count)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  // Synchronous ROM, one cycle of latency.
  always @(posedge CLK) if (MemRd) MemData <= rom(MemAddr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model state
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];       // addresses queued for decode, oldest first
  logic [31:0] m_fpc;
  logic [31:0] m_pend;
  bit          m_inflight;
  logic [31:0] delivered[$];   // addresses decode has accepted
  logic [31:0] issued[$];      // addresses sent to the ROM
  bit          obs_rd;
  bit          obs_val;
  logic [2:0]  obs_cnt;

  task automatic model_reset();
    exp_q.delete();
    m_fpc      = RESET_PC;
    m_pend     = '0;
    m_inflight = 1'b0;
  endtask

  // ---------------------------------------------------------------- driver + scoreboard
  // Called on a falling edge; drives one cycle, checks it against the
  // queue-level model, advances the model across the next rising edge.
  task automatic step(input bit rd, input logic [31:0] ra, input bit rdy);
    int          sz;
    bit          live, byp, e_rd, e_val;
    logic [31:0] head;
    Redirect = rd; RedirectAddr = ra; InsReady = rdy;
    #1;
    sz   = exp_q.size();
    live = m_inflight && !rd;
    byp  = 1'b0;
`ifdef IPQ_BYPASS_EN
    byp  = live && (sz == 0);
`endif
    e_rd  = !rd && (sz + int'(m_inflight)) < DEPTH;
    e_val = (sz != 0 && !rd) || byp;
    head  = byp ? m_pend : ((sz != 0) ? exp_q[0] : 32'h0);
    obs_rd = MemRd; obs_val = InsValid; obs_cnt = Count;

    n_cmp++;
    if (MemRd !== e_rd) begin
      n_fail++; $display("FAIL memrd t=%0t: got %b want %b", $time, MemRd, e_rd);
    end
    if (e_rd) begin
      n_cmp++;
      if (MemAddr !== m_fpc) begin
        n_fail++; $display("FAIL memaddr t=%0t: got %h want %h", $time, MemAddr, m_fpc);
      end
      issued.push_back(m_fpc);
    end
    n_cmp++;
    if (Count !== 3'(sz)) begin
      n_fail++; $display("FAIL count t=%0t: got %0d want %0d", $time, Count, sz);
    end
    n_cmp++;
    if (InsValid !== e_val) begin
      n_fail++; $display("FAIL insvalid t=%0t: got %b want %b", $time, InsValid, e_val);
    end
    if (e_val) begin
      n_cmp++;
      if (InsAddr !== head || Ins !== rom(head)) begin
        n_fail++;
        $display("FAIL head t=%0t: got %h/%h want %h/%h", $time, InsAddr, Ins, head, rom(head));
      end
    end

    if (rd) begin
      exp_q.delete();
      m_fpc      = {ra[31:2], 2'b00};
      m_inflight = 1'b0;
    end else begin
      if (e_val && rdy) begin
        delivered.push_back(head);
        if (!byp) void'(exp_q.pop_front());
      end
      if (live && !(byp && rdy)) exp_q.push_back(m_pend);
      if (e_rd) begin
        m_pend = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
      m_inflight = e_rd;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1; Redirect = 1'b0; InsReady = 1'b0;
    repeat (n) @(negedge CLK);
    Reset = 1'b0;
    model_reset();
    issued.delete();
    delivered.delete();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (MemRd !== 1'b0 || InsValid !== 1'b0 || Count !== 3'd0 ||
          Ins !== 32'h0 || InsAddr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state: got rd=%b v=%b cnt=%0d ins=%h addr=%h want all zero",
                 MemRd, InsValid, Count, Ins, InsAddr);
      end
      @(negedge CLK);
    end
    Reset = 1'b0;
    model_reset();
    issued.delete();
    delivered.delete();
  endtask

  task automatic test_stream();
    int first_rd = -1;
    int first_val = -1;
    logic [31:0] want;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (obs_rd && first_rd < 0) first_rd = i;
      if (obs_val && first_val < 0) first_val = i;
    end
    n_cmp++;
    if (first_rd != 0 || first_val - first_rd != LAT) begin
      n_fail++;
      $display("FAIL stream_latency: first MemRd cycle %0d, first InsValid cycle %0d, want 0 and %0d",
               first_rd, first_val, LAT);
    end
    for (int k = 0; k < 4; k++) begin
      want = 32'(k * 4);
      n_cmp++;
      if (k >= issued.size() || issued[k] !== want) begin
        n_fail++; $display("FAIL stream_issue[%0d]: got %h want %h", k,
                           (k < issued.size()) ? issued[k] : 32'hx, want);
      end
      n_cmp++;
      if (k >= delivered.size() || delivered[k] !== want) begin
        n_fail++; $display("FAIL stream_deliver[%0d]: got %h want %h", k,
                           (k < delivered.size()) ? delivered[k] : 32'hx, want);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] want;
    do_reset(2);
    repeat (10) step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (issued.size() != 4 || Count !== 3'd4 || MemRd !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_fill: got reads=%0d count=%0d memrd=%b want 4/4/0",
               issued.size(), Count, MemRd);
    end
    issued.delete();
    delivered.delete();
    repeat (8) step(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      want = 32'(k * 4);
      n_cmp++;
      if (k >= delivered.size() || delivered[k] !== want) begin
        n_fail++; $display("FAIL stall_drain[%0d]: got %h want %h", k,
                           (k < delivered.size()) ? delivered[k] : 32'hx, want);
      end
    end
    n_cmp++;
    if (issued.size() == 0 || issued[0] !== 32'h10) begin
      n_fail++; $display("FAIL stall_resume: got %h want 00000010",
                         (issued.size() != 0) ? issued[0] : 32'hx);
    end
  endtask

  task automatic test_redirect();
    do_reset(2);
    repeat (4) step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (Count !== 3'd3) begin
      n_fail++; $display("FAIL redirect_setup: count got %0d want 3", Count);
    end
    step(1'b1, 32'h40, 1'b1);
    n_cmp++;
    if (obs_val !== 1'b0 || obs_rd !== 1'b0) begin
      n_fail++; $display("FAIL redirect_cycle: got valid=%b rd=%b want 0/0", obs_val, obs_rd);
    end
    issued.delete();
    delivered.delete();
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (obs_cnt !== 3'd0 || issued.size() == 0 || issued[0] !== 32'h40) begin
      n_fail++; $display("FAIL redirect_next: got count=%0d addr=%h want 0/00000040",
                         obs_cnt, (issued.size() != 0) ? issued[0] : 32'hx);
    end
    repeat (5) step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (delivered.size() == 0 || delivered[0] !== 32'h40) begin
      n_fail++; $display("FAIL redirect_deliver: got %h want 00000040",
                         (delivered.size() != 0) ? delivered[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_targets();
    logic [31:0] tgt[3];
    logic [31:0] want[3][3];
    tgt[0] = 32'h0000_0043; want[0][0] = 32'h40; want[0][1] = 32'h44; want[0][2] = 32'h48;
    tgt[1] = 32'hFFFF_FFF8; want[1][0] = 32'hFFFF_FFF8; want[1][1] = 32'hFFFF_FFFC; want[1][2] = 32'h0;
    tgt[2] = 32'h0000_0202; want[2][0] = 32'h200; want[2][1] = 32'h204; want[2][2] = 32'h208;
    for (int t = 0; t < 3; t++) begin
      // The third case is preceded by another redirect: the last one wins.
      if (t == 2) step(1'b1, 32'h100, 1'b1);
      step(1'b1, tgt[t], 1'b1);
      issued.delete();
      delivered.delete();
      repeat (7) step(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (issued.size() == 0 || issued[0] !== want[t][0]) begin
        n_fail++; $display("FAIL target_issue[%0d]: got %h want %h", t,
                           (issued.size() != 0) ? issued[0] : 32'hx, want[t][0]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (k >= delivered.size() || delivered[k] !== want[t][k]) begin
          n_fail++; $display("FAIL target_deliver[%0d][%0d]: got %h want %h", t, k,
                             (k < delivered.size()) ? delivered[k] : 32'hx, want[t][k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (5) step(1'b0, 32'h0, 1'b1);
    Redirect = 1'b0; InsReady = 1'b1;
    #2 Reset = 1'b1;
    #1;
    n_cmp++;
    if (MemRd !== 1'b0 || InsValid !== 1'b0 || Count !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: got rd=%b v=%b cnt=%0d want 0/0/0",
                         MemRd, InsValid, Count);
    end
    @(negedge CLK);
    do_reset(2);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (issued.size() == 0 || issued[0] !== RESET_PC) begin
      n_fail++; $display("FAIL async_restart: got %h want %h",
                         (issued.size() != 0) ? issued[0] : 32'hx, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          rd, rdy;
    logic [31:0] ra;
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 19) == 0);
      ra  = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      step(rd, ra, rdy);
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    @(negedge CLK);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_targets();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
